nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs wide additions on a single 4-bit ripple adder slice, one nibble per clock, least significant nibble first. The nibble carry is held in a register between cycles. It sits between a requesting unit and the 4-bit adder datapath, so 4·NIBBLES-bit operands share one nibble adder in place of a wide combinational chain. A start/busy/done handshake frames each operation. Results are registered and held until the next accepted start.

## Interface
- NIBBLES, default 4: operand width is 4·NIBBLES bits; legal range 1–16.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request; sampled only in IDLE or DONE_S.
- A  input  4·NIBBLES  operand A; latched when START is accepted.
- B  input  4·NIBBLES  operand B; latched when START is accepted.
- CIN  input  1  carry-in for an add; latched when START is accepted.
- OP  input  1  0 = add, 1 = subtract; latched when START is accepted. Only meaningful with SUB_EN defined.
- BUSY  output  1  high while nibbles are being processed.
- DONE  output  1  one-cycle pulse when SUM/CARRY/OVF become valid.
- SUM  output  4·NIBBLES  result.
- CARRY  output  1  carry out of the MSB nibble (no-borrow flag in subtract).
- OVF  output  1  two's-complement overflow: carry into the MSB xor carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE_S. All outputs, registers and the nibble index reset to 0; state resets to IDLE.
- IDLE or DONE_S with START=1:
  - latch A, B, OP;
  - carry register ← CIN (add) or 1 (subtract);
  - index ← 0;
  - go to RUN.
- IDLE with START=0: stay in IDLE.
- DONE_S with START=0: go to IDLE.
- RUN, each cycle:
  - nibble adder input a = A[4i+3:4i];
  - nibble adder input b = B[4i+3:4i] (add) or its bitwise inverse (subtract);
  - nibble adder carry-in = carry register;
  - sum nibble is written to internal result slice i;
  - carry register ← nibble carry-out;
  - index increments.
- RUN, last nibble (i = NIBBLES−1):
  - SUM ← full result;
  - CARRY ← carry-out;
  - OVF ← carry into bit 3 xor carry-out of that nibble;
  - go to DONE_S.
- START while in RUN is ignored; the operation in progress is not disturbed.
- Operand inputs may change freely after the accepting edge.
- SUM, CARRY and OVF are updated only on the edge entering DONE_S. They hold until the next operation completes, so partial results are never visible.
- Arithmetic is modulo 2^(4·NIBBLES). Subtract computes A + ~B + 1; CIN is ignored.
- Reset asserted mid-operation aborts immediately: state goes to IDLE, outputs go to 0, and no DONE pulse is produced.

## Timing
- Edge e0 accepts START. Edges e1…eN process nibbles 0…N−1, where N = NIBBLES.
- BUSY is high from e0 to eN, i.e. N cycles.
- DONE is high for exactly one cycle, from eN to eN+1.
- Result latency from accepting edge to DONE is N cycles.
- START held high during the DONE cycle is accepted at eN+1, giving back-to-back throughput of one operation per N+1 cycles.
- BUSY and DONE are never high together.
- NIBBLES=1: BUSY high 1 cycle, DONE on the next cycle.

## Configuration
- SUB_EN:
  - Defined: OP selects add or subtract as described above.
  - Undefined: OP is ignored; every operation is an add using CIN; the inversion logic is not compiled.

## Test plan
All cases use NIBBLES=4.
- Add timing: A=0x1234, B=0x1111, CIN=0, START one cycle → BUSY for 4 cycles, then DONE for 1 cycle with SUM=0x2345, CARRY=0, OVF=0.
- Full carry ripple: A=0xFFFF, B=0x0001, CIN=0 → SUM=0x0000, CARRY=1, OVF=0. A=0xFFFF, B=0x0000, CIN=1 → same result.
- Signed overflow: A=0x7FFF, B=0x0001 → SUM=0x8000, CARRY=0, OVF=1.
- Subtract (SUB_EN defined, OP=1):
  - A=0x0005, B=0x0007 → SUM=0xFFFE, CARRY=0, OVF=0.
  - A=0x8000, B=0x0001 → SUM=0x7FFF, CARRY=1, OVF=1.
- Handshake:
  - START pulsed in RUN with new operands → ignored; original result returned.
  - START held through DONE → second operation begins at the next edge.
- Reset: RST_N dropped during the 2nd RUN cycle → BUSY=0, DONE=0, SUM=0 immediately; no DONE pulse after release. A subsequent START works normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add (optionally subtract with SUB_EN) on one 4-bit adder slice, one nibble per cycle, LSB nibble first.
// Latency: DONE pulses NIBBLES cycles after the accepting edge; results held until the next completion.
// Backpressure: START is only honoured in IDLE/DONE_S; START during RUN is ignored.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    input  logic                 cin_i,
    input  logic                 op_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] sum_o,
    output logic                 carry_o,
    output logic                 ovf_o
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_e;

    state_e        state_q;
    logic [W-1:0]  a_q, b_q, res_q, res_d, sum_q;
    logic [IW-1:0] idx_q;
    logic          carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [IW+1:0] base;
    logic [3:0]    a_nib, b_nib;
    logic [4:0]    nib_sum;
    logic          c3, last, carry_init;

    assign base  = {idx_q, 2'b00};
    assign a_nib = a_q[base +: 4];
    assign last  = (idx_q == IW'(NIBBLES - 1));

`ifdef SUB_EN
    logic sub_q;
    // Subtract is A + ~B + 1: invert B per nibble and seed the carry with 1.
    assign b_nib      = b_q[base +: 4] ^ {4{sub_q}};
    assign carry_init = op_i ? 1'b1 : cin_i;
`else
    logic unused_op;
    assign unused_op  = op_i;
    assign b_nib      = b_q[base +: 4];
    assign carry_init = cin_i;
`endif

    assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the sum bit, for signed overflow.
    assign c3      = a_nib[3] ^ b_nib[3] ^ nib_sum[3];

    always_comb begin
        res_d              = res_q;
        res_d[base +: 4]   = nib_sum[3:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE_S: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
`ifdef SUB_EN
                        sub_q   <= op_i;
`endif
                        carry_q <= carry_init;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= nib_sum[4];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        sum_q   <= res_d;
                        cout_q  <= nib_sum[4];
                        ovf_q   <= c3 ^ nib_sum[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE_S;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign carry_o = cout_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4): directed table, handshake/reset sequences, random vs model.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
`ifdef SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start_i, cin_i, op_i;
    logic [15:0] a_i, b_i;
    logic        busy_o, done_o, carry_o, ovf_o;
    logic [15:0] sum_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] held_sum = '0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
        .cin_i(cin_i), .op_i(op_i), .busy_o(busy_o), .done_o(done_o),
        .sum_o(sum_o), .carry_o(carry_o), .ovf_o(ovf_o)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, op;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: wide integer arithmetic; overflow from operand/result signs.
    task automatic model(input logic [15:0] a, b, input logic cin, op,
                         output logic [15:0] s, output logic c, o);
        logic [16:0] full;
        logic [15:0] bb;
        logic        ci, sub;
        sub  = op & SUB_ON;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
        s    = full[15:0];
        c    = full[16];
        o    = (a[15] == bb[15]) && (s[15] != a[15]);
    endtask

    // From #1 after the accepting edge, step until DONE (bounded).
    task automatic wait_done(output int lat, output int bcnt, output bit partial);
        lat = 0; bcnt = 0; partial = 0;
        while (!done_o && lat < 40) begin
            if (busy_o) bcnt++;
            if (sum_o !== held_sum) partial = 1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_done(input string nm, input int lat, bcnt, input bit partial,
                              input logic [15:0] es, input logic ec, eo);
        chk({nm, " done_seen"}, 32'(lat < 40), 1);
        chk({nm, " latency"}, lat, N);
        chk({nm, " busy_cycles"}, bcnt, N);
        chk({nm, " no_partial"}, 32'(partial), 0);
        chk({nm, " busy_at_done"}, busy_o, 0);
        chk({nm, " sum"}, sum_o, es);
        chk({nm, " carry"}, carry_o, ec);
        chk({nm, " ovf"}, ovf_o, eo);
        held_sum = es;
    endtask

    task automatic run_op(input string nm, input logic [15:0] a, b, input logic cin, o_p,
                          input logic [15:0] es, input logic ec, eo);
        int lat, bcnt;
        bit partial;
        @(negedge clk);
        a_i = a; b_i = b; cin_i = cin; op_i = o_p; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom); op_i = 1'($urandom);
        wait_done(lat, bcnt, partial);
        check_done(nm, lat, bcnt, partial, es, ec, eo);
        @(posedge clk); #1;
        chk({nm, " done_pulse_end"}, done_o, 0);
        chk({nm, " held"}, sum_o, es);
    endtask

    initial begin
        vec_t        vt[6];
        logic [15:0] es;
        logic        ec, eo;
        int          lat, bcnt, dcnt;
        bit          partial;

        vt[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
`ifdef SUB_EN
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
        vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0};
`endif

        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; op_i = 1'b0;
        #12;
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset sum", sum_o, 0);
        chk("reset carry", carry_o, 0);
        chk("reset ovf", ovf_o, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].op,
                   vt[i].s, vt[i].c, vt[i].o);

        // START pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0; op_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        a_i = 16'hFFFF; b_i = 16'hFFFF; cin_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 0; dcnt = 0;
        while (!done_o && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("run_start latency", lat + 2, N);
        chk("run_start sum", sum_o, 16'h2345);
        chk("run_start carry", carry_o, 0);
        held_sum = 16'h2345;
        @(posedge clk); #1;
        chk("run_start idle", busy_o, 0);

        // START held through DONE: second op accepted on the edge leaving DONE_S.
        @(negedge clk);
        a_i = 16'h0F0F; b_i = 16'h0101; cin_i = 1'b0; op_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        a_i = 16'h8000; b_i = 16'h8001; cin_i = 1'b0;
        wait_done(lat, bcnt, partial);
        check_done("b2b_first", lat, bcnt, partial, 16'h1010, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("b2b accept busy", busy_o, 1);
        chk("b2b accept done", done_o, 0);
        wait_done(lat, bcnt, partial);
        check_done("b2b_second", lat, bcnt, partial, 16'h0001, 1'b1, 1'b1);

        // Reset during the 2nd RUN cycle aborts with no DONE.
        @(negedge clk);
        a_i = 16'hAAAA; b_i = 16'h1111; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy_o, 0);
        chk("abort done", done_o, 0);
        chk("abort sum", sum_o, 0);
        chk("abort carry", carry_o, 0);
        chk("abort ovf", ovf_o, 0);
        held_sum = '0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dcnt++;
        end
        chk("abort no_done", dcnt, 0);
        run_op("post_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            logic [15:0] ra, rb;
            logic        rc, ro;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); ro = 1'($urandom);
            if (r % 8 == 0) rb = ~ra;
            model(ra, rb, rc, ro, es, ec, eo);
            run_op($sformatf("rand%0d", r), ra, rb, rc, ro, es, ec, eo);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
